serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 169 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial unsigned adder. A single full-adder slice (two half adders
//   plus a carry flop) adds one bit per clock, LSB first. A three-state FSM
//   (IDLE -> RUN -> DONE -> IDLE) sequences the operation.
//
//   Ports
//     CLK    in   system clock, rising edge
//     RST    in   asynchronous active-high reset
//     start  in   add request, accepted only in IDLE
//     A, B   in   WIDTH-bit operands, captured on the accepting edge
//     busy   out  high while in RUN
//     done   out  one-cycle pulse in DONE, result valid
//     out    out  WIDTH-bit sum, held until the next accepted start
//     cy     out  carry out of the MSB, held with out
//
//   Timing: start accepted at edge k -> RUN on edges k+1..k+WIDTH ->
//   done high between edges k+WIDTH and k+WIDTH+1.
// ---------------------------------------------------------------------------

// One half adder; two of them plus an OR form the full-adder slice.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cy
);

  // Counter needs to reach WIDTH-1 only; never wraps inside RUN.
  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers: bit 0 is always the bit being added.
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // FSM decode strobes
  logic load, step, last;

  // ---------------------------------------------------------------------
  // Full-adder slice: a + b + carry from two half adders.
  // ---------------------------------------------------------------------
  logic s0, c0, sum_bit, c1, carry_d;

  half_adder u_ha0 (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (carry_q),
    .s (sum_bit),
    .c (c1)
  );

  // The two half-adder carries can never both be set.
  assign carry_d = c0 | c1;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next state and outputs. start is only looked at in IDLE, so a start
  // held through RUN/DONE does nothing until the FSM is back in IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath. out fills from the MSB end so that after WIDTH shifts the
  // first (LSB) sum bit has landed in out[0].
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out     <= '0;
      cy      <= 1'b0;
    end else if (load) begin
      a_sr    <= A;
      b_sr    <= B;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out     <= '0;
      cy      <= 1'b0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry_q <= carry_d;
      out     <= {sum_bit, out[WIDTH-1:1]};
      // Hold at terminal count on the final edge rather than wrapping.
      cnt_q   <= last ? cnt_q : cnt_q + CW'(1);
      if (last) cy <= carry_d;
    end
  end

  // ---------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------
  a_busy_done_excl: assert property (@(posedge CLK) disable iff (RST)
    !(busy && done));

  a_done_one_cycle: assert property (@(posedge CLK) disable iff (RST)
    done |=> !done);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Scoreboard bench for two instances (WIDTH=8 and WIDTH=16) sharing clock
//   and reset. Drivers push the expected {cy,out} when they issue a start;
//   per-instance monitors pop and compare whenever done is seen, and also
//   check busy length and start-to-done latency.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic        start8 = 1'b0, busy8, done8, cy8;
  logic [7:0]  A8 = '0, B8 = '0, out8;
  logic        start16 = 1'b0, busy16, done16, cy16;
  logic [15:0] A16 = '0, B16 = '0, out16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc8  = 0;
  int acc16 = 0;
  int busyn8 = 0;
  int busyn16 = 0;

  logic [32:0] q8[$];
  logic [32:0] q16[$];

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .out(out8), .cy(cy8)
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .start(start16), .A(A16), .B(B16),
    .busy(busy16), .done(done16), .out(out16), .cy(cy16)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitors (sample on falling edge). done seen here is the state entered
  // at edge acc+WIDTH, i.e. the value the DUT presents on edge acc+WIDTH+1.
  // -------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (RST) begin
      busyn8 = 0;
    end else begin
      if (busy8) busyn8++;
      if (done8) begin
        if (q8.size() == 0) begin
          chk("w8_unexpected_done", {25'd0, cy8, out8}, 33'h1_DEAD_BEEF);
        end else begin
          chk("w8_result", {24'd0, cy8, out8}, q8.pop_front());
          chk("w8_busy_len", 33'(busyn8), 33'd8);
          chk("w8_latency", 33'(cyc - acc8), 33'd8);
          chk("w8_busy_in_done", {32'd0, busy8}, 33'd0);
        end
        busyn8 = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      busyn16 = 0;
    end else begin
      if (busy16) busyn16++;
      if (done16) begin
        if (q16.size() == 0) begin
          chk("w16_unexpected_done", {16'd0, cy16, out16}, 33'h1_DEAD_BEEF);
        end else begin
          chk("w16_result", {16'd0, cy16, out16}, q16.pop_front());
          chk("w16_busy_len", 33'(busyn16), 33'd16);
          chk("w16_latency", 33'(cyc - acc16), 33'd16);
          chk("w16_busy_in_done", {32'd0, busy16}, 33'd0);
        end
        busyn16 = 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drivers. Called just after a rising edge with the DUT in IDLE; they
  // return just after the edge that takes the DUT back to IDLE.
  // -------------------------------------------------------------------------
  task automatic wait8();
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (q8.size() == 0) return;
    end
    chk("w8_timeout_pending", 33'(q8.size()), 33'd0);
    q8.delete();
  endtask

  task automatic wait16();
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (q16.size() == 0) return;
    end
    chk("w16_timeout_pending", 33'(q16.size()), 33'd0);
    q16.delete();
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
    start8 = 1'b1; A8 = a; B8 = b;
    q8.push_back({24'd0, e});
    @(posedge CLK); #1;
    acc8 = cyc;
    start8 = 1'b0;
    A8 = ~a; B8 = 8'($urandom);   // operands must be ignored from here on
    wait8();
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e);
    start16 = 1'b1; A16 = a; B16 = b;
    q16.push_back({16'd0, e});
    @(posedge CLK); #1;
    acc16 = cyc;
    start16 = 1'b0;
    A16 = ~a; B16 = 16'($urandom);
    wait16();
  endtask

  initial begin
    logic [15:0] ra, rb;

    // Reset state
    #12;
    chk("rst_busy", {32'd0, busy8}, 33'd0);
    chk("rst_done", {32'd0, done8}, 33'd0);
    chk("rst_out",  {25'd0, out8},  33'd0);
    chk("rst_cy",   {32'd0, cy8},   33'd0);

    // Start on the very first edge after reset release
    RST = 1'b0;
    go8(8'h5A, 8'h3C, 9'h096);
    go8(8'hFF, 8'h01, 9'h100);
    go8(8'hFF, 8'hFF, 9'h1FE);
    go8(8'h00, 8'h00, 9'h000);

    // start held high through RUN and DONE, operands flipped to 0xFF:
    // first result untouched, exactly one follow-on op accepted in IDLE.
    start8 = 1'b1; A8 = 8'h12; B8 = 8'h34;
    q8.push_back(33'h046);
    q8.push_back(33'h1FE);
    @(posedge CLK); #1;
    acc8 = cyc;
    A8 = 8'hFF; B8 = 8'hFF;
    repeat (10) @(posedge CLK);   // edge k+WIDTH+2 is the second accept
    #1;
    acc8 = cyc;
    start8 = 1'b0;
    wait8();

    // Asynchronous reset after 4 RUN edges of 0xAA+0x55
    start8 = 1'b1; A8 = 8'hAA; B8 = 8'h55;
    @(posedge CLK); #1;
    start8 = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("mid_run_out_partial", {25'd0, out8}, 33'h0F0);
    #1 RST = 1'b1;
    #1;
    chk("arst_busy", {32'd0, busy8}, 33'd0);
    chk("arst_done", {32'd0, done8}, 33'd0);
    chk("arst_out",  {25'd0, out8},  33'd0);
    chk("arst_cy",   {32'd0, cy8},   33'd0);
    @(posedge CLK); #3 RST = 1'b0;
    repeat (14) @(posedge CLK);   // any done here has no queue entry
    #1;
    go8(8'h01, 8'h01, 9'h002);

    // WIDTH=16 directed
    go16(16'hFFFF, 16'h0001, 17'h10000);
    go16(16'h1234, 16'h4321, 17'h05555);
    go16(16'h8000, 16'h8000, 17'h10000);
    go16(16'hABCD, 16'h1111, 17'h0BCDE);
    go16(16'hFFFF, 16'hFFFF, 17'h1FFFE);

    // Random regression, reference is plain integer addition
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      go8(ra[7:0], rb[7:0], 9'(ra[7:0]) + 9'(rb[7:0]));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      go16(ra, rb, 17'(ra) + 17'(rb));
    end

    repeat (4) @(posedge CLK);
    #1;
    chk("q8_drained",  33'(q8.size()),  33'd0);
    chk("q16_drained", 33'(q16.size()), 33'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
